spi_master: RTL and testbench

- Upstream driver for the SPI memory block. It generates sclk_pin, cs_pin and mosi_pin from the system clock and captures miso_pin.
- Each transaction is a 16-bit frame: a 7-bit address, then the R/W flag, then 8 data bits, all MSB first.
- A host FSM or bench requests a transaction with start. For reads, the captured data is returned on rdata.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_div.sv | 34 +++
 rtl/spi_master.sv | 156 +++++++++++++++
 tb/tb_spi_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI master slice.
//   - spi_state_t : master FSM state encoding
//   - RW_READ / RW_WRITE : values of the R/W flag in the frame
//   - ADDR_W_DEF / DATA_W_DEF / FRAME_W_DEF : default frame geometry
package spi_pkg;

    localparam int ADDR_W_DEF  = 7;
    localparam int DATA_W_DEF  = 8;
    localparam int FRAME_W_DEF = ADDR_W_DEF + 1 + DATA_W_DEF;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period divider for the SPI master.
// Counts CLK_DIV enabled clk cycles and flags the last one with half_tick,
// so the consumer acts on the edge that closes each half-period.
//   clk       in  system clock
//   reset     in  synchronous reset, active-high
//   clear     in  force the count back to 0
//   en        in  count enable
//   half_tick out high on the final cycle of each half-period
module spi_clk_div #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic half_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign half_tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= half_tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI host driving a 16-bit {addr, rw, data} frame, MSB first.
// sclk idles low; the first half-period of SHIFT is low so that the 16
// rising edges (memory sample points) each sit mid-bit, and the 16th
// falling edge closes SHIFT. Total start-to-done latency is 34*CLK_DIV.
// Optional build macro: SPI_MISO_SYNC_EN adds a 2-flop miso synchronizer
// (needs CLK_DIV >= 3); otherwise miso is captured directly.
//   clk, reset           system clock, synchronous active-high reset
//   start, rw, addr, wdata  transaction request, latched in IDLE
//   busy, done, rdata    status and read data (all registered)
//   sclk_pin, cs_pin, mosi_pin, miso_pin  SPI pins
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 5,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    localparam int FRAME_W = ADDR_W + 1 + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] FIRST_RD = CNT_W'(ADDR_W + 1);

    spi_state_t         state, state_n;
    logic [FRAME_W-1:0] sreg, sreg_n;
    logic [DATA_W-1:0]  rd_sreg, rd_n, rdata_n;
    logic [CNT_W-1:0]   bit_cnt, bit_n;
    logic               rw_q, rw_n;
    logic               sclk_n, cs_n, mosi_n, done_n, busy_n;
    logic               half_tick, div_en, miso_s;

    assign div_en = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .reset     (reset),
        .clear     (!div_en),
        .en        (div_en),
        .half_tick (half_tick)
    );

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_sync;
    always_ff @(posedge clk) begin
        if (reset) miso_sync <= '0;
        else       miso_sync <= {miso_sync[0], miso_pin};
    end
    assign miso_s = miso_sync[1];
`else
    assign miso_s = miso_pin;
`endif

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        rd_n    = rd_sreg;
        rdata_n = rdata;
        bit_n   = bit_cnt;
        rw_n    = rw_q;
        sclk_n  = sclk_pin;
        cs_n    = cs_pin;
        mosi_n  = mosi_pin;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    sreg_n  = {addr, rw, wdata};
                    rw_n    = rw;
                    cs_n    = 1'b0;
                    mosi_n  = addr[ADDR_W-1];
                    sclk_n  = 1'b0;
                    bit_n   = '0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (half_tick) state_n = SHIFT;
            end
            SHIFT: begin
                if (half_tick) begin
                    sclk_n = !sclk_pin;
                    if (sclk_pin) begin
                        // Falling edge: bit_cnt still names the bit whose
                        // high phase is ending, which is the capture point.
                        bit_n = bit_cnt + 1'b1;
                        if (rw_q == RW_READ && bit_cnt >= FIRST_RD)
                            rd_n = {rd_sreg[DATA_W-2:0], miso_s};
                        if (bit_cnt == LAST_BIT) begin
                            mosi_n  = 1'b0;
                            state_n = HOLD;
                        end else begin
                            mosi_n = sreg[FRAME_W-2];
                            sreg_n = sreg << 1;
                        end
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    cs_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = DONE;
                    if (rw_q == RW_READ) rdata_n = rd_sreg;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sreg     <= '0;
            rd_sreg  <= '0;
            rdata    <= '0;
            bit_cnt  <= '0;
            rw_q     <= 1'b0;
            sclk_pin <= 1'b0;
            cs_pin   <= 1'b1;
            mosi_pin <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            rd_sreg  <= rd_n;
            rdata    <= rdata_n;
            bit_cnt  <= bit_n;
            rw_q     <= rw_n;
            sclk_pin <= sclk_n;
            cs_pin   <= cs_n;
            mosi_pin <= mosi_n;
            done     <= done_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master (CLK_DIV=5).
// A negedge monitor records mosi at each sclk rise, counts sclk edges and
// done pulses, and plays the memory by driving miso after each falling edge.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, sclk_pin, cs_pin, mosi_pin;
    logic [7:0] rdata;
    logic       miso_pin = 1'b0;

    spi_master #(.CLK_DIV(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin)
    );

    always #5 clk = !clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // monitor / memory model
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;
    logic [15:0] mosi_cap  = '0;
    logic [7:0]  miso_data = '0;
    int rise_cnt = 0, fall_cnt = 0, done_cnt = 0, cs_fall_cyc = 0;

    always @(negedge clk) begin
        if (prev_cs && !cs_pin) begin
            rise_cnt    = 0;
            fall_cnt    = 0;
            mosi_cap    = '0;
            miso_pin    = 1'b0;
            cs_fall_cyc = cyc;
        end
        if (!prev_sclk && sclk_pin) begin
            mosi_cap = {mosi_cap[14:0], mosi_pin};
            rise_cnt++;
        end
        if (prev_sclk && !sclk_pin) begin
            fall_cnt++;
            if (fall_cnt >= 8 && fall_cnt <= 15) miso_pin = miso_data[15-fall_cnt];
        end
        if (done) done_cnt++;
        prev_sclk = sclk_pin;
        prev_cs   = cs_pin;
    end

    int t0 = 0;

    task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk); #1;
        rw = r; addr = a; wdata = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk); #1;
            if (done) begin
                seen = 1'b1;
                lat  = cyc - t0;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int lat, dbase, d1, bad;

    initial begin
        // reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs",   32'(cs_pin),   32'd1);
        chk("rst_sclk", 32'(sclk_pin), 32'd0);
        chk("rst_mosi", 32'(mosi_pin), 32'd0);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_done", 32'(done),     32'd0);
        chk("rst_rdata", 32'(rdata),   32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cs_pin !== 1'b1 || sclk_pin !== 1'b0 || mosi_pin !== 1'b0 ||
                busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk("idle_stable", 32'(bad), 32'd0);

        // write 0x44 <- 0xBB
        dbase = done_cnt;
        launch(1'b0, 7'h44, 8'hBB);
        wait_done("wr", lat);
        chk("wr_latency", 32'(lat), 32'd170);
        chk("wr_mosi",  32'(mosi_cap), 32'h88BB);
        chk("wr_rises", 32'(rise_cnt), 32'd16);
        chk("wr_busy_at_done", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("wr_busy_after", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("wr_done_cnt", 32'(done_cnt - dbase), 32'd1);
        chk("wr_rdata", 32'(rdata), 32'd0);

        // read 0x44, memory returns 0x89
        miso_data = 8'h89;
        launch(1'b1, 7'h44, 8'h00);
        wait_done("rd", lat);
        chk("rd_latency", 32'(lat), 32'd170);
        chk("rd_mosi_hdr", 32'(mosi_cap[15:8]), 32'h89);
        chk("rd_rdata", 32'(rdata), 32'h89);

        // start while busy must be ignored
        repeat (3) @(negedge clk);
        dbase = done_cnt;
        launch(1'b0, 7'h12, 8'h34);
        repeat (40) @(negedge clk);
        #1;
        rw = 1'b1; addr = 7'h7F; wdata = 8'hFF; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done("guard", lat);
        chk("guard_mosi", 32'(mosi_cap), 32'h2434);
        repeat (20) @(negedge clk);
        #1;
        chk("guard_done_cnt", 32'(done_cnt - dbase), 32'd1);
        chk("guard_rdata", 32'(rdata), 32'h89);

        // back-to-back with start held high
        dbase = done_cnt;
        @(negedge clk); #1;
        rw = 1'b0; addr = 7'h55; wdata = 8'hA5; start = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        addr = 7'h2A; wdata = 8'h5C;
        wait_done("b2b1", lat);
        d1 = cyc;
        chk("b2b_frame1", 32'(mosi_cap), 32'hAAA5);
        bad = 1;
        for (int i = 0; i < 10 && bad != 0; i++) begin
            @(negedge clk); #1;
            if (!cs_pin) bad = 0;
        end
        start = 1'b0;
        chk("b2b_cs_fall_seen", 32'(bad), 32'd0);
        chk("b2b_gap", 32'(cs_fall_cyc - d1), 32'd2);
        t0 = cs_fall_cyc;
        wait_done("b2b2", lat);
        chk("b2b_latency2", 32'(lat), 32'd170);
        chk("b2b_frame2", 32'(mosi_cap), 32'h545C);
        repeat (10) @(negedge clk);
        #1;
        chk("b2b_done_cnt", 32'(done_cnt - dbase), 32'd2);

        // reset after the 6th sclk rise of a read
        miso_data = 8'hC3;
        launch(1'b1, 7'h10, 8'h00);
        bad = 1;
        for (int i = 0; i < 200 && bad != 0; i++) begin
            @(negedge clk); #1;
            if (rise_cnt >= 6) bad = 0;
        end
        chk("mid_rise6_seen", 32'(bad), 32'd0);
        dbase = done_cnt;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_cs",    32'(cs_pin),   32'd1);
        chk("mid_sclk",  32'(sclk_pin), 32'd0);
        chk("mid_busy",  32'(busy),     32'd0);
        chk("mid_done",  32'(done),     32'd0);
        chk("mid_rdata", 32'(rdata),    32'd0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        #1;
        chk("mid_no_done", 32'(done_cnt - dbase), 32'd0);

        miso_data = 8'h5A;
        launch(1'b1, 7'h33, 8'h00);
        wait_done("post", lat);
        chk("post_latency", 32'(lat), 32'd170);
        chk("post_mosi", 32'(mosi_cap), 32'h6700);
        chk("post_rdata", 32'(rdata), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
